// File: rtl/adc_avg_decimator.sv
// Boxcar averager/decimator for the sixteen LTC2335-16 channels.
// One shared adder walks the captured snapshot, one channel per clk, after each accepted strobe.
module adc_avg_decimator #(
  parameter int LOG2_AVG = 4,
  parameter int N_CH     = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sample_stb,
  input  logic [15:0] s0,
  input  logic [15:0] s1,
  input  logic [15:0] s2,
  input  logic [15:0] s3,
  input  logic [15:0] s4,
  input  logic [15:0] s5,
  input  logic [15:0] s6,
  input  logic [15:0] s7,
  input  logic [15:0] s8,
  input  logic [15:0] s9,
  input  logic [15:0] s10,
  input  logic [15:0] s11,
  input  logic [15:0] s12,
  input  logic [15:0] s13,
  input  logic [15:0] s14,
  input  logic [15:0] s15,
  output logic [15:0] avg0,
  output logic [15:0] avg1,
  output logic [15:0] avg2,
  output logic [15:0] avg3,
  output logic [15:0] avg4,
  output logic [15:0] avg5,
  output logic [15:0] avg6,
  output logic [15:0] avg7,
  output logic [15:0] avg8,
  output logic [15:0] avg9,
  output logic [15:0] avg10,
  output logic [15:0] avg11,
  output logic [15:0] avg12,
  output logic [15:0] avg13,
  output logic [15:0] avg14,
  output logic [15:0] avg15,
  output logic        avg_valid,
  output logic        busy,
  output logic        overrun
);
  localparam int AW  = 16 + LOG2_AVG;
  localparam int CHW = $clog2(N_CH);
  localparam int CW  = 9;
  localparam logic [CW-1:0]  CNT_LAST = CW'((1 << LOG2_AVG) - 1);
  localparam logic [CHW-1:0] CH_LAST  = CHW'(N_CH - 1);

  typedef enum logic {IDLE, ACCUM} state_t;

  logic [15:0]          s_in   [N_CH];
  logic [15:0]          snap_q [N_CH];
  logic [15:0]          snap_d [N_CH];
  logic signed [AW-1:0] acc_q  [N_CH];
  logic signed [AW-1:0] acc_d  [N_CH];
  logic [15:0]          avg_q  [N_CH];
  logic [15:0]          avg_d  [N_CH];
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [CHW-1:0]       ch_q, ch_d;
  state_t               state_q, state_d;
  logic                 busy_q, busy_d;
  logic                 overrun_q, overrun_d;
  logic                 avg_valid_q, avg_valid_d;
  logic                 done_q, done_d;
  logic signed [AW-1:0] sum;
  logic                 final_pass;

  assign s_in = '{s0, s1, s2, s3, s4, s5, s6, s7, s8, s9, s10, s11, s12, s13, s14, s15};

  assign sum        = acc_q[ch_q] + AW'($signed(snap_q[ch_q]));
  assign final_pass = (cnt_q == CNT_LAST);

  always_comb begin
    snap_d      = snap_q;
    acc_d       = acc_q;
    avg_d       = avg_q;
    cnt_d       = cnt_q;
    ch_d        = ch_q;
    state_d     = state_q;
    busy_d      = busy_q;
    overrun_d   = overrun_q;
    done_d      = 1'b0;
    // avg_valid trails the last channel write by one cycle so every avg is settled
    avg_valid_d = done_q;
    case (state_q)
      IDLE: begin
        if (sample_stb) begin
          snap_d  = s_in;
          ch_d    = '0;
          state_d = ACCUM;
          busy_d  = 1'b1;
        end
      end
      ACCUM: begin
        if (sample_stb) overrun_d = 1'b1;
        if (final_pass) begin
          avg_d[ch_q] = 16'(sum >>> LOG2_AVG);
          acc_d[ch_q] = '0;
        end else begin
          acc_d[ch_q] = sum;
        end
        ch_d = ch_q + CHW'(1);
        if (ch_q == CH_LAST) begin
          ch_d    = '0;
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = final_pass;
          cnt_d   = final_pass ? '0 : cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      snap_q      <= '{default: '0};
      acc_q       <= '{default: '0};
      avg_q       <= '{default: '0};
      cnt_q       <= '0;
      ch_q        <= '0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
      avg_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      snap_q      <= snap_d;
      acc_q       <= acc_d;
      avg_q       <= avg_d;
      cnt_q       <= cnt_d;
      ch_q        <= ch_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
      avg_valid_q <= avg_valid_d;
      done_q      <= done_d;
    end
  end

  assign avg0  = avg_q[0];
  assign avg1  = avg_q[1];
  assign avg2  = avg_q[2];
  assign avg3  = avg_q[3];
  assign avg4  = avg_q[4];
  assign avg5  = avg_q[5];
  assign avg6  = avg_q[6];
  assign avg7  = avg_q[7];
  assign avg8  = avg_q[8];
  assign avg9  = avg_q[9];
  assign avg10 = avg_q[10];
  assign avg11 = avg_q[11];
  assign avg12 = avg_q[12];
  assign avg13 = avg_q[13];
  assign avg14 = avg_q[14];
  assign avg15 = avg_q[15];

  assign avg_valid = avg_valid_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;
endmodule

// File: tb/tb_adc_avg_decimator.sv
// Bench for adc_avg_decimator: three instances (LOG2_AVG = 0, 1, 4) share one stimulus stream
// and are checked every cycle against a cycle-numbered behavioural model.
module tb_adc_avg_decimator;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sample_stb = 1'b0;
  logic [15:0] s     [16];
  logic [15:0] stim  [16];
  logic [15:0] avg_o [3][16];
  logic        avg_v  [3];
  logic        busy_o [3];
  logic        ovr_o  [3];

  int chk = 0;
  int fail = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    adc_avg_decimator #(.LOG2_AVG(g == 0 ? 0 : (g == 1 ? 1 : 4)), .N_CH(16)) u_dut (
      .clk(clk), .rst(rst), .sample_stb(sample_stb),
      .s0(s[0]), .s1(s[1]), .s2(s[2]), .s3(s[3]), .s4(s[4]), .s5(s[5]), .s6(s[6]), .s7(s[7]),
      .s8(s[8]), .s9(s[9]), .s10(s[10]), .s11(s[11]), .s12(s[12]), .s13(s[13]), .s14(s[14]), .s15(s[15]),
      .avg0(avg_o[g][0]), .avg1(avg_o[g][1]), .avg2(avg_o[g][2]), .avg3(avg_o[g][3]),
      .avg4(avg_o[g][4]), .avg5(avg_o[g][5]), .avg6(avg_o[g][6]), .avg7(avg_o[g][7]),
      .avg8(avg_o[g][8]), .avg9(avg_o[g][9]), .avg10(avg_o[g][10]), .avg11(avg_o[g][11]),
      .avg12(avg_o[g][12]), .avg13(avg_o[g][13]), .avg14(avg_o[g][14]), .avg15(avg_o[g][15]),
      .avg_valid(avg_v[g]), .busy(busy_o[g]), .overrun(ovr_o[g]));
  end

  function automatic int lg(int i);
    return (i == 0) ? 0 : ((i == 1) ? 1 : 4);
  endfunction

  function automatic longint floor_div(longint a, longint d);
    longint q;
    q = a / d;
    if ((a % d) != 0 && a < 0) q = q - 1;
    return q;
  endfunction

  // Model state, all in absolute cycle numbers (cyc = number of posedges seen).
  int     acc_ok   [3];
  int     busy_lo  [3];
  int     busy_hi  [3];
  int     mask_lo  [3];
  int     mask_hi  [3];
  int     pend_cyc [3];
  int     vcyc     [3];
  int     nacc     [3];
  bit     exp_ovr  [3];
  longint msum     [3][16];
  int     pend_avg [3][16];
  int     exp_avg  [3][16];

  always @(posedge clk) begin
    cyc++;
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        acc_ok[i] = 0; busy_lo[i] = 1; busy_hi[i] = 0; mask_lo[i] = 1; mask_hi[i] = 0;
        pend_cyc[i] = -1; vcyc[i] = -1; nacc[i] = 0; exp_ovr[i] = 1'b0;
        for (int k = 0; k < 16; k++) begin msum[i][k] = 0; exp_avg[i][k] = 0; end
      end else begin
        if (pend_cyc[i] == cyc) begin
          for (int k = 0; k < 16; k++) exp_avg[i][k] = pend_avg[i][k];
          vcyc[i] = cyc;
        end
        if (sample_stb) begin
          if (cyc < acc_ok[i]) begin
            exp_ovr[i] = 1'b1;
          end else begin
            acc_ok[i] = cyc + 17; busy_lo[i] = cyc; busy_hi[i] = cyc + 15;
            nacc[i]++;
            for (int k = 0; k < 16; k++) msum[i][k] += longint'($signed(s[k]));
            if (nacc[i] == (1 << lg(i))) begin
              for (int k = 0; k < 16; k++) begin
                pend_avg[i][k] = int'(floor_div(msum[i][k], longint'(1 << lg(i))));
                msum[i][k] = 0;
              end
              nacc[i] = 0; pend_cyc[i] = cyc + 17; mask_lo[i] = cyc + 1; mask_hi[i] = cyc + 16;
            end
          end
        end
      end
    end
  end

  int vcnt [3];
  int bcnt [3];

  always @(negedge clk) begin
    if (cyc > 0) begin
      for (int i = 0; i < 3; i++) begin
        logic eb, ev;
        eb = (cyc >= busy_lo[i]) && (cyc <= busy_hi[i]);
        ev = (cyc == vcyc[i]);
        if (avg_v[i] === 1'b1) vcnt[i]++;
        if (busy_o[i] === 1'b1) bcnt[i]++;
        chk++;
        if (busy_o[i] !== eb) begin
          fail++; $display("FAIL busy[%0d] cyc=%0d got=%b exp=%b", i, cyc, busy_o[i], eb);
        end
        chk++;
        if (avg_v[i] !== ev) begin
          fail++; $display("FAIL avg_valid[%0d] cyc=%0d got=%b exp=%b", i, cyc, avg_v[i], ev);
        end
        chk++;
        if (ovr_o[i] !== exp_ovr[i]) begin
          fail++; $display("FAIL overrun[%0d] cyc=%0d got=%b exp=%b", i, cyc, ovr_o[i], exp_ovr[i]);
        end
        if (!(cyc >= mask_lo[i] && cyc <= mask_hi[i])) begin
          for (int k = 0; k < 16; k++) begin
            chk++;
            if (avg_o[i][k] !== 16'(exp_avg[i][k])) begin
              fail++;
              $display("FAIL avg[%0d][%0d] cyc=%0d got=%0d exp=%0d", i, k, cyc,
                       $signed(avg_o[i][k]), exp_avg[i][k]);
            end
          end
        end
      end
    end
  end

  task automatic lit(input string name, input int got, input int exp);
    chk++;
    if (got != exp) begin
      fail++; $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      for (int k = 0; k < 16; k++) s[k] = 16'($urandom);
    end
  endtask

  task automatic do_stb();
    for (int k = 0; k < 16; k++) s[k] = stim[k];
    sample_stb = 1'b1;
    @(negedge clk);
    sample_stb = 1'b0;
    for (int k = 0; k < 16; k++) s[k] = 16'($urandom);
  endtask

  task automatic rand_stim();
    for (int k = 0; k < 16; k++) stim[k] = 16'($urandom);
  endtask

  task automatic phase_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(1);
  endtask

  int vb [3];
  int bb;
  logic [15:0] first [16];

  initial begin
    for (int k = 0; k < 16; k++) begin s[k] = '0; stim[k] = '0; end
    idle(3);
    rst = 1'b0;
    idle(1);
    lit("reset_busy", int'(busy_o[2]), 0);
    lit("reset_avg", int'(avg_o[2][7]), 0);

    // Pass-through on the LOG2_AVG=0 instance
    phase_reset();
    bb = bcnt[0];
    for (int k = 0; k < 16; k++) stim[k] = 16'(k * 100 - 800);
    do_stb();
    idle(16);
    lit("pt_valid_t16", int'(avg_v[0]), 0);
    idle(1);
    lit("pt_valid_t17", int'(avg_v[0]), 1);
    idle(1);
    lit("pt_valid_t18", int'(avg_v[0]), 0);
    lit("pt_busy_cycles", bcnt[0] - bb, 16);
    for (int k = 0; k < 16; k++) lit($sformatf("pt_avg%0d", k), int'($signed(avg_o[0][k])), k * 100 - 800);

    // Negative rounding and extremes on the LOG2_AVG=1 instance
    phase_reset();
    rand_stim(); stim[0] = 16'hFFFF; do_stb(); idle(20);
    rand_stim(); stim[0] = 16'hFFFE; do_stb(); idle(20);
    lit("round_neg", int'($signed(avg_o[1][0])), -2);
    rand_stim(); stim[0] = 16'h7FFF; do_stb(); idle(20);
    rand_stim(); stim[0] = 16'h7FFF; do_stb(); idle(20);
    lit("max_pos", int'($signed(avg_o[1][0])), 32767);
    rand_stim(); stim[0] = 16'h8000; do_stb(); idle(20);
    rand_stim(); stim[0] = 16'h8000; do_stb(); idle(20);
    lit("max_neg", int'($signed(avg_o[1][0])), -32768);

    // Averaging: 16 strobes, ch3 alternating 1000/1003, others -5
    phase_reset();
    for (int i = 0; i < 3; i++) vb[i] = vcnt[i];
    for (int n = 0; n < 16; n++) begin
      for (int k = 0; k < 16; k++) stim[k] = 16'(-5);
      stim[3] = (n % 2 == 0) ? 16'd1000 : 16'd1003;
      do_stb();
      idle(99);
    end
    lit("avg_pulses_l4", vcnt[2] - vb[2], 1);
    lit("avg_pulses_l1", vcnt[1] - vb[1], 8);
    lit("avg3_l4", int'($signed(avg_o[2][3])), 1001);
    lit("avg0_l4", int'($signed(avg_o[2][0])), -5);
    lit("avg3_l1", int'($signed(avg_o[1][3])), 1001);

    // Overrun: second strobe 10 cycles after the first is dropped
    phase_reset();
    rand_stim(); first = stim; do_stb(); idle(9);
    rand_stim(); do_stb(); idle(30);
    lit("ovr_10", int'(ovr_o[0]), 1);
    for (int k = 0; k < 16; k++) lit($sformatf("ovr_first%0d", k), int'(avg_o[0][k]), int'(first[k]));
    phase_reset();
    rand_stim(); do_stb(); idle(15);
    rand_stim(); do_stb(); idle(20);
    lit("ovr_16", int'(ovr_o[0]), 1);
    phase_reset();
    vb[0] = vcnt[0];
    rand_stim(); do_stb(); idle(16);
    rand_stim(); do_stb(); idle(20);
    lit("ovr_17", int'(ovr_o[0]), 0);
    lit("ovr_17_pulses", vcnt[0] - vb[0], 2);

    // Reset mid-pass at ch=7, then fresh strobes must not see stale sums
    phase_reset();
    for (int n = 0; n < 3; n++) begin rand_stim(); do_stb(); idle(29); end
    rand_stim(); do_stb(); idle(7);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    lit("rst_busy", int'(busy_o[2]), 0);
    lit("rst_valid", int'(avg_v[2]), 0);
    lit("rst_avg_l0", int'(avg_o[0][5]), 0);
    for (int n = 0; n < 16; n++) begin
      for (int k = 0; k < 16; k++) stim[k] = 16'd40;
      do_stb(); idle(19);
    end
    idle(5);
    lit("fresh_avg_l4", int'($signed(avg_o[2][9])), 40);
    lit("fresh_avg_l1", int'($signed(avg_o[1][9])), 40);

    // Decimation count with legal random spacing
    phase_reset();
    for (int i = 0; i < 3; i++) vb[i] = vcnt[i];
    for (int n = 0; n < 64; n++) begin rand_stim(); do_stb(); idle($urandom_range(16, 39)); end
    idle(30);
    lit("dec_l0", vcnt[0] - vb[0], 64);
    lit("dec_l1", vcnt[1] - vb[1], 32);
    lit("dec_l4", vcnt[2] - vb[2], 4);

    // Random spacing including overruns, model-checked only
    phase_reset();
    for (int n = 0; n < 80; n++) begin rand_stim(); do_stb(); idle($urandom_range(0, 29)); end
    idle(40);

    $display("TB_RESULT checks=%0d failures=%0d", chk, fail);
    $finish;
  end
endmodule
